// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with an iterative multiply/divide unit and HI/LO.
//   clk, rst_n        : clock, asynchronous active-low reset
//   a, b              : operands (rs, rt/immediate)
//   alu_control       : operation select
//   start             : launch MULT/MULTU/DIV/DIVU (ignored while busy)
//   result/zero/overflow : combinational ALU outputs
//   busy, done        : mult/div in progress, one-cycle completion pulse
//   hi, lo            : architectural HI/LO registers
//   stall             : pipeline hold request (combinational)
module alu_muldiv #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    input  logic             start,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = 2 * WIDTH;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLTU = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_MFHI = 4'b1101;
    localparam logic [3:0] OP_MFLO = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;     // mult: partial product high half; div: remainder
    logic [WIDTH-1:0] acc_lo;     // mult: multiplier/product low; div: dividend/quotient
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_raw;      // original dividend, returned in HI on divide by zero
    logic             op_div;
    logic             sgn_a;
    logic             sgn_b;
    logic             b_zero;

    logic             is_md;
    logic             accept;

    assign is_md  = (alu_control[3:2] == 2'b10);
    assign accept = (state == S_IDLE) && start && is_md;

    // Single-cycle ALU
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ov;
    logic             sub_ov;

    assign sum    = a + b;
    assign diff   = a - b;
    assign add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (alu_control)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  begin result = sum;  overflow = add_ov; end
            OP_XOR:  result = a ^ b;
            OP_SLTU: result = WIDTH'(a < b);
            OP_SUB:  begin result = diff; overflow = sub_ov; end
            OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
            OP_NOR:  result = ~(a | b);
            OP_MFHI: result = hi;
            OP_MFLO: result = lo;
            default: result = '0;
        endcase
    end

    assign zero  = (result == '0);
    assign stall = busy && ((alu_control == OP_MFHI) || (alu_control == OP_MFLO)
                            || (start && is_md));

    // Operand signs and magnitudes at launch; unsigned ops (bit 0 set) stay raw
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;

    assign sa_in    = ~alu_control[0] & a[WIDTH-1];
    assign sb_in    = ~alu_control[0] & b[WIDTH-1];
    assign mag_a_in = sa_in ? (WIDTH'(0) - a) : a;
    assign mag_b_in = sb_in ? (WIDTH'(0) - b) : b;

    // One shift-add multiply step and one restoring divide step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shl;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    assign mul_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
    assign div_shl = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge  = (div_shl >= {1'b0, opnd});
    assign div_rem = div_ge ? WIDTH'(div_shl - {1'b0, opnd}) : div_shl[WIDTH-1:0];

    // Sign fixup and special cases applied in FIX
    logic [PW-1:0]    prod_fix;
    logic [WIDTH-1:0] hi_fix;
    logic [WIDTH-1:0] lo_fix;

    always_comb begin
        prod_fix = {acc_hi, acc_lo};
        hi_fix   = acc_hi;
        lo_fix   = acc_lo;
        if (sgn_a ^ sgn_b) begin
            prod_fix = PW'(0) - {acc_hi, acc_lo};
        end
        if (!op_div) begin
            hi_fix = prod_fix[PW-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end else if (b_zero) begin
            hi_fix = a_raw;
            lo_fix = '1;
        end else begin
            lo_fix = (sgn_a ^ sgn_b) ? (WIDTH'(0) - acc_lo) : acc_lo;
            hi_fix = sgn_a ? (WIDTH'(0) - acc_hi) : acc_hi;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_RUN;
            S_RUN:   if (cnt == CW'(1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            a_raw  <= '0;
            op_div <= 1'b0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            b_zero <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        busy   <= 1'b1;
                        cnt    <= CW'(WIDTH);
                        op_div <= alu_control[1];
                        sgn_a  <= sa_in;
                        sgn_b  <= sb_in;
                        a_raw  <= a;
                        b_zero <= (b == '0);
                        acc_hi <= '0;
                        if (alu_control[1]) begin
                            acc_lo <= mag_a_in;
                            opnd   <= mag_b_in;
                        end else begin
                            acc_lo <= mag_b_in;
                            opnd   <= mag_a_in;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt - CW'(1);
                    if (op_div) begin
                        acc_hi <= div_rem;
                        acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised + directed bench for alu_muldiv with a scoreboard of pending HI/LO results.
module tb_alu_muldiv;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a, b, result, hi, lo;
    logic [3:0]  alu_control;
    logic        start, zero, overflow, busy, done, stall;

    logic [7:0]  a8, b8, result8, hi8, lo8;
    logic [3:0]  ctl8;
    logic        start8, zero8, ov8, busy8, done8, stall8;

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .alu_control(alu_control),
        .start(start), .result(result), .zero(zero), .overflow(overflow),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .stall(stall)
    );

    alu_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .alu_control(ctl8),
        .start(start8), .result(result8), .zero(zero8), .overflow(ov8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .stall(stall8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          last_k = -1000;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    function automatic longint sext(input logic [31:0] v, input int w);
        longint u = longint'(v) & ((longint'(1) << w) - 1);
        if (u >= (longint'(1) << (w - 1))) return u - (longint'(1) << w);
        return u;
    endfunction

    // Reference for MULT/MULTU/DIV/DIVU at width w (<= 32)
    task automatic md_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                            input int w, output logic [31:0] ho, output logic [31:0] lo_o);
        longint      mask = (longint'(1) << w) - 1;
        longint      ux = longint'(x) & mask;
        longint      uy = longint'(y) & mask;
        longint      sx = sext(x, w);
        longint      sy = sext(y, w);
        longint      p;
        logic [63:0] up;
        case (op)
            4'd8: begin
                p = sx * sy;
                ho = 32'((p >>> w) & mask);
                lo_o = 32'(p & mask);
            end
            4'd9: begin
                up = 64'(ux) * 64'(uy);
                ho = 32'((up >> w) & 64'(mask));
                lo_o = 32'(up & 64'(mask));
            end
            default: begin
                if (uy == 0) begin
                    lo_o = 32'(mask);
                    ho = 32'(ux);
                end else if (op == 4'd10 && sx == -(longint'(1) << (w - 1)) && sy == -1) begin
                    lo_o = 32'(ux);
                    ho = 32'd0;
                end else if (op == 4'd10) begin
                    lo_o = 32'((sx / sy) & mask);
                    ho = 32'((sx % sy) & mask);
                end else begin
                    lo_o = 32'(ux / uy);
                    ho = 32'(ux % uy);
                end
            end
        endcase
    endtask

    // Reference for the combinational result/overflow at width 32
    task automatic comb_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                              output logic [31:0] r, output logic ov);
        longint sx = sext(x, 32);
        longint sy = sext(y, 32);
        longint s;
        r = '0;
        ov = 1'b0;
        case (op)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2:  begin
                s = sx + sy;
                r = 32'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd3:  r = x ^ y;
            4'd4:  r = (x < y) ? 32'd1 : 32'd0;
            4'd6:  begin
                s = sx - sy;
                r = 32'(s);
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
            4'd12: r = ~(x | y);
            4'd13: r = m_hi;
            4'd14: r = m_lo;
            default: r = '0;
        endcase
    endtask

    // One cycle of stimulus with combinational, busy and stall checks
    task automatic drive(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic st);
        int          k;
        bit          bsy;
        logic [31:0] r, eh, el;
        logic        ov;
        @(negedge clk);
        alu_control = op;
        a = x;
        b = y;
        start = st;
        k = cyc;
        bsy = (k >= last_k + 1) && (k <= last_k + W + 1);
        #1;
        comb_model(op, x, y, r, ov);
        chk("result", result, r);
        chk("zero", zero, (r == 0));
        chk("overflow", overflow, ov);
        chk("busy", busy, bsy);
        chk("stall", stall, bsy && (op == 4'd13 || op == 4'd14 || (st && is_md(op))));
        if (st && is_md(op) && !bsy) begin
            md_model(op, x, y, W, eh, el);
            sb.push_back('{hi: eh, lo: el, due: k + W + 2});
            last_k = k;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(4'd0, $urandom, $urandom, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compare each done pulse against the oldest pending expectation
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0 && cyc > sb[0].due) begin
            chk("done_missing", done, 1'b1);
            void'(sb.pop_front());
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("done_unexpected", done, 1'b0);
            end else begin
                e = sb.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_latency", cyc, e.due);
                m_hi = e.hi;
                m_lo = e.lo;
            end
        end
    end

    task automatic run8(input string nm, input logic [3:0] op, input logic [7:0] x,
                        input logic [7:0] y);
        int          k;
        bit          got;
        logic [31:0] eh, el;
        md_model(op, {24'b0, x}, {24'b0, y}, 8, eh, el);
        @(negedge clk);
        ctl8 = op;
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        k = cyc;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(posedge clk);
            #1;
            got = done8;
        end
        chk({nm, "_latency"}, cyc - k, 10);
        chk({nm, "_hi"}, hi8, eh[7:0]);
        chk({nm, "_lo"}, lo8, el[7:0]);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a = '0; b = '0; alu_control = '0; start = 1'b0;
        a8 = '0; b8 = '0; ctl8 = '0; start8 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy8", busy8, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational cases
        drive(4'd2, 32'h7FFF_FFFF, 32'h1, 1'b0);
        chk("add_ovf_result", result, 32'h8000_0000);
        chk("add_ovf_flag", overflow, 1'b1);
        drive(4'd6, 32'd5, 32'd5, 1'b0);
        chk("sub_zero", zero, 1'b1);
        drive(4'd7, 32'h8000_0000, 32'h1, 1'b0);
        chk("slt_min", result, 32'h1);
        drive(4'd4, 32'h8000_0000, 32'h1, 1'b0);
        chk("sltu_min", result, 32'h0);
        drive(4'd3, 32'hF0F0, 32'hFF00, 1'b0);
        chk("xor", result, 32'h0FF0);

        // MULT -3*5
        drive(4'd8, 32'hFFFF_FFFD, 32'd5, 1'b1);
        idle(W + 2);
        chk("mult_done", done, 1'b1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU with MFLO during busy returning the stale LO
        drive(4'd9, 32'hFFFF_FFFF, 32'd2, 1'b1);
        drive(4'd14, 32'h0, 32'h0, 1'b0);
        chk("mflo_stale", result, 32'hFFFF_FFF1);
        chk("mflo_stall", stall, 1'b1);
        idle(W + 1);
        chk("multu_hi", hi, 32'h1);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7/2 with an ignored second start, then a back-to-back start in the done cycle
        drive(4'd10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        idle(3);
        drive(4'd11, 32'd100, 32'd3, 1'b1);
        idle(W - 3);
        drive(4'd11, 32'd7, 32'd0, 1'b1);
        chk("div_done", done, 1'b1);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        idle(W + 2);
        chk("divu0_lo", lo, 32'hFFFF_FFFF);
        chk("divu0_hi", hi, 32'h7);

        drive(4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(W + 2);
        chk("div_min_lo", lo, 32'h8000_0000);
        chk("div_min_hi", hi, 32'h0);

        // Reset in the middle of a MULT
        drive(4'd8, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        idle(9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        sb.delete();
        last_k = -1000;
        m_hi = '0;
        m_lo = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(4'd8, 32'd6, 32'd7, 1'b1);
        idle(W + 2);
        chk("post_rst_lo", lo, 32'd42);
        chk("post_rst_hi", hi, 32'd0);

        // Randomised mix of all codes
        for (int i = 0; i < 1500; i++) begin
            drive(4'($urandom_range(0, 15)), pick(), pick(), ($urandom_range(0, 3) == 0));
        end
        for (int i = 0; i < W + 5 && sb.size() > 0; i++) idle(1);
        chk("sb_empty", sb.size(), 0);

        // WIDTH=8 instance
        run8("multu8", 4'd9, 8'hFF, 8'hFF);
        chk("multu8_hi_const", hi8, 8'hFE);
        chk("multu8_lo_const", lo8, 8'h01);
        run8("div8_min", 4'd10, 8'h80, 8'hFF);
        chk("div8_min_lo_const", lo8, 8'h80);
        chk("div8_min_hi_const", hi8, 8'h00);
        for (int i = 0; i < 8; i++) begin
            run8("rand8", 4'(8 + $urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 20)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
